// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: a DEPTH-entry byte FIFO plus a dispatcher that hands
// bytes one at a time to a start/busy style transmitter.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);
    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEVEL_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO  = DATA_W'(0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_s;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              tx_start_r;
    logic              push_s;
    logic              pop_s;
    logic              ovf_set_s;

    // Write acceptance uses the registered full flag; a write during flush is discarded.
    always_comb begin
        push_s    = wr_en && !full_r && !flush;
        ovf_set_s = wr_en && full_r;
    end

    // Dispatcher next-state and pop decision.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r && !tx_busy) begin
                    pop_s   = 1'b1;
                    state_s = LAUNCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next occupancy; flush wins over any push/pop in the same cycle.
    always_comb begin
        level_s = level_r;
        if (flush) begin
            level_s = LEVEL_ZERO;
        end else if (push_s && !pop_s) begin
            level_s = level_r + LEVEL_ONE;
        end else if (!push_s && pop_s) begin
            level_s = level_r - LEVEL_ONE;
        end else begin
            level_s = level_r;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LEVEL_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                wr_ptr_r <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
                rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            end
            level_r <= level_s;
            full_r  <= (level_s == FULL_LEVEL);
            empty_r <= (level_s == LEVEL_ZERO);
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Dispatcher state and the registered transmitter interface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= DATA_ZERO;
        end else begin
            state_r    <= state_s;
            tx_start_r <= pop_s;
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter and a
// byte scoreboard (expected queue filled at write, compared at launch).
module tb_uart_tx_fifo;
    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       hold_busy;
    logic [4:0] busy_cnt;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         gap_q[$];
    int         n_launch = 0;
    int         ncyc = 0;
    int         last_fall = -1000;
    logic       prev_busy = 1'b0;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises one clock after start and lasts 20 clocks.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt <= 5'd0;
        end else if (tx_start) begin
            busy_cnt <= 5'd20;
        end else if (busy_cnt != 5'd0) begin
            busy_cnt <= busy_cnt - 5'd1;
        end
    end
    assign tx_busy = hold_busy | (busy_cnt != 5'd0);

    // Launch monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (prev_busy && !tx_busy) last_fall = ncyc;
            prev_busy = tx_busy;
            if (tx_start) begin
                obs_q.push_back(tx_data);
                gap_q.push_back(ncyc - last_fall);
                n_launch++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic sb_drain(input int n, input int budget);
        int w = 0;
        while (obs_q.size() < n && w < budget) begin
            tick();
            w++;
        end
        check("launch_count", obs_q.size(), n);
        while (obs_q.size() > 0) begin
            logic [7:0] o;
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check("unexpected_launch", {24'd0, o}, 32'hFFFF_FFFF);
            end else begin
                check("tx_data_order", {24'd0, o}, {24'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while ((tx_busy || !empty) && w < budget) begin
            tick();
            w++;
        end
        check("idle_reached", {31'd0, (w < budget)}, 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        int pushed;
        int base;
        int w;
        int g;
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        clr_ovf = 1'b0; hold_busy = 1'b0;
        repeat (3) tick();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        reset = 1'b1;
        repeat (2) tick();

        // 1: three bytes back to back, latency and inter-launch spacing
        gap_q.delete();
        wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41); tick();
        check("t1_no_start_yet", tx_start, 0);
        check("t1_level1", level, 1);
        wr_data = 8'h42; exp_q.push_back(8'h42); tick();
        check("t1_start", tx_start, 1);
        check("t1_tx_data", tx_data, 32'h41);
        check("t1_level_pushpop", level, 1);
        wr_data = 8'h43; exp_q.push_back(8'h43); tick();
        wr_en = 1'b0;
        check("t1_start_one_cycle", tx_start, 0);
        check("t1_level2", level, 2);
        sb_drain(3, 300);
        if (gap_q.size() >= 3) begin
            g = gap_q.pop_front();
            g = gap_q.pop_front();
            check("t1_gap2", g, 2);
            g = gap_q.pop_front();
            check("t1_gap3", g, 2);
        end else begin
            check("t1_gap_count", gap_q.size(), 3);
        end
        wait_idle(100);
        check("t1_empty_end", empty, 1);

        // 2: fill to 16 while transmitter busy, overflow behaviour
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(i[7:0], 1'b1);
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        write_byte(8'h55, 1'b0);
        check("t2_overflow", overflow, 1);
        check("t2_level_kept", level, 16);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("t2_ovf_cleared", overflow, 0);
        clr_ovf = 1'b1; write_byte(8'h66, 1'b0); clr_ovf = 1'b0;
        check("t2_ovf_set_wins", overflow, 1);
        hold_busy = 1'b0;
        sb_drain(16, 700);
        wait_idle(100);
        check("t2_level0", level, 0);

        // 3: write coinciding with an IDLE pop at level 5
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'hA0 + i[7:0], 1'b1);
        check("t3_level5", level, 5);
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5); hold_busy = 1'b0;
        tick();
        wr_en = 1'b0;
        check("t3_level_same", level, 5);
        check("t3_popped", tx_start, 1);
        sb_drain(6, 400);
        wait_idle(100);

        // 4: 40 random bytes with random write enable, kept below full
        pushed = 0;
        base = n_launch;
        w = 0;
        while (pushed < 40 && w < 4000) begin
            if ($urandom_range(0, 1) == 1 && (pushed - (n_launch - base)) < 14) begin
                wr_en = 1'b1;
                wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            w++;
        end
        wr_en = 1'b0;
        check("t4_pushed", pushed, 40);
        sb_drain(40, 1500);
        wait_idle(100);
        check("t4_overflow", overflow, 1);

        // 5: reset while in WAIT_DONE with 7 queued
        for (int i = 0; i < 8; i++) write_byte(8'hB0 + i[7:0], 1'b1);
        check("t5_level7", level, 7);
        reset = 1'b0;
        #1;
        check("t5_level0", level, 0);
        check("t5_empty", empty, 1);
        check("t5_tx_start", tx_start, 0);
        check("t5_tx_data", tx_data, 0);
        check("t5_overflow", overflow, 0);
        sb_drain(1, 5);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (30) tick();
        check("t5_no_relaunch", obs_q.size(), 0);
        write_byte(8'h77, 1'b1);
        sb_drain(1, 100);
        wait_idle(100);

        // 6: flush at level 9 with a byte in flight; write in flush cycle dropped
        for (int i = 0; i < 10; i++) write_byte(8'hC0 + i[7:0], 1'b1);
        check("t6_level9", level, 9);
        flush = 1'b1;
        write_byte(8'hEE, 1'b0);
        flush = 1'b0;
        check("t6_level0", level, 0);
        check("t6_empty", empty, 1);
        check("t6_inflight_data", tx_data, 32'hC0);
        sb_drain(1, 5);
        exp_q.delete();
        wait_idle(100);
        repeat (30) tick();
        check("t6_no_relaunch", obs_q.size(), 0);
        write_byte(8'h5A, 1'b1);
        sb_drain(1, 100);
        wait_idle(100);
        check("t6_final_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
